// File: rtl/pipelined_divider.sv
// -----------------------------------------------------------------------------
// pipelined_divider
//
// Fully pipelined restoring integer divider. One dividend/divisor pair can be
// accepted every clock; quotient, remainder, flags and the caller tag come out
// WIDTH+2 clocks later when the downstream never stalls.
//
// Pipeline:
//   capture  : operands and tag registered exactly as presented
//   stage 0  : magnitudes, result signs, divide-by-zero and overflow flags
//   stage 1..WIDTH : one quotient bit each, MSB first, restoring subtraction
//   output   : sign correction / special-case results, registered outputs
//
// Ports:
//   clk_in          system clock, rising edge
//   rst_in          synchronous active-high reset, drops everything in flight
//   data_valid_in   operand pair valid (ignored while ready_in = 0)
//   dividend_in     dividend, WIDTH bits
//   divisor_in      divisor, WIDTH bits
//   tag_in          opaque caller tag, returned with the result
//   ready_in        downstream can take a result; also the pipeline enable
//   ready_out       equals ready_in
//   data_valid_out  result valid
//   quotient_out    quotient
//   remainder_out   remainder
//   tag_out         tag of the returned operation
//   error_out       divide by zero (qualified by data_valid_out)
//   overflow_out    signed MIN / -1 (qualified by data_valid_out)
//   busy_out        at least one operation anywhere in the pipeline
// -----------------------------------------------------------------------------
module pipelined_divider #(
    parameter int WIDTH     = 16,
    parameter int SIGNED    = 0,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 data_valid_in,
    input  logic [WIDTH-1:0]     dividend_in,
    input  logic [WIDTH-1:0]     divisor_in,
    input  logic [TAG_WIDTH-1:0] tag_in,
    input  logic                 ready_in,
    output logic                 ready_out,
    output logic                 data_valid_out,
    output logic [WIDTH-1:0]     quotient_out,
    output logic [WIDTH-1:0]     remainder_out,
    output logic [TAG_WIDTH-1:0] tag_out,
    output logic                 error_out,
    output logic                 overflow_out,
    output logic                 busy_out
);

    localparam bit               IS_SIGNED = (SIGNED != 0);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

    // Everything one operation carries from stage to stage.
    //   rem : partial remainder (WIDTH+1 bits)
    //   qd  : shift register; remaining dividend bits leave from the top while
    //         resolved quotient bits enter at the bottom
    //   raw : dividend exactly as presented, needed for the special cases
    typedef struct packed {
        logic                 valid;
        logic [WIDTH:0]       rem;
        logic [WIDTH-1:0]     qd;
        logic [WIDTH-1:0]     dmag;
        logic                 qneg;
        logic                 rneg;
        logic                 err;
        logic                 ovf;
        logic [WIDTH-1:0]     raw;
        logic [TAG_WIDTH-1:0] tag;
    } stage_t;

    // ------------------------------------------------------------------ capture
    logic                 r_cap_valid;
    logic [WIDTH-1:0]     r_cap_dividend;
    logic [WIDTH-1:0]     r_cap_divisor;
    logic [TAG_WIDTH-1:0] r_cap_tag;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cap_valid    <= 1'b0;
            r_cap_dividend <= '0;
            r_cap_divisor  <= '0;
            r_cap_tag      <= '0;
        end else if (ready_in) begin
            r_cap_valid <= data_valid_in;
            if (data_valid_in) begin
                r_cap_dividend <= dividend_in;
                r_cap_divisor  <= divisor_in;
                r_cap_tag      <= tag_in;
            end
        end
    end

    // ------------------------------------------------------------------ stage 0
    logic             w_dividend_neg;
    logic             w_divisor_neg;
    logic [WIDTH-1:0] w_dividend_mag;
    logic [WIDTH-1:0] w_divisor_mag;
    logic             w_div_zero;
    logic             w_overflow;
    stage_t           w_stage0;

    assign w_dividend_neg = IS_SIGNED && r_cap_dividend[WIDTH-1];
    assign w_divisor_neg  = IS_SIGNED && r_cap_divisor[WIDTH-1];
    // |MIN| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit magnitude.
    assign w_dividend_mag = w_dividend_neg ? -r_cap_dividend : r_cap_dividend;
    assign w_divisor_mag  = w_divisor_neg  ? -r_cap_divisor  : r_cap_divisor;
    assign w_div_zero     = (r_cap_divisor == '0);
    assign w_overflow     = IS_SIGNED && (r_cap_dividend == MIN_VAL)
                            && (r_cap_divisor == {WIDTH{1'b1}});

    always_comb begin
        w_stage0       = '0;
        w_stage0.valid = r_cap_valid;
        w_stage0.rem   = '0;
        w_stage0.qd    = w_dividend_mag;
        w_stage0.dmag  = w_divisor_mag;
        w_stage0.qneg  = w_dividend_neg ^ w_divisor_neg;
        w_stage0.rneg  = w_dividend_neg;
        w_stage0.err   = w_div_zero;
        w_stage0.ovf   = w_overflow;
        w_stage0.raw   = r_cap_dividend;
        w_stage0.tag   = r_cap_tag;
    end

    stage_t r_stage [0:WIDTH];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_stage[0] <= '0;
        end else if (ready_in) begin
            r_stage[0] <= w_stage0;
        end
    end

    // ------------------------------------------------------- quotient-bit stages
    genvar gi;
    generate
        for (gi = 1; gi <= WIDTH; gi++) begin : gen_bit_stage
            logic [WIDTH:0] w_shift;
            logic [WIDTH:0] w_diff;
            logic           w_fits;
            stage_t         w_next;

            // Bring down the next dividend bit, then subtract if it fits.
            // A zero divisor always fits, which yields an all-ones quotient
            // and the dividend magnitude as remainder.
            assign w_shift = {r_stage[gi-1].rem[WIDTH-1:0], r_stage[gi-1].qd[WIDTH-1]};
            assign w_diff  = w_shift - {1'b0, r_stage[gi-1].dmag};
            assign w_fits  = (w_shift >= {1'b0, r_stage[gi-1].dmag});

            always_comb begin
                w_next     = r_stage[gi-1];
                w_next.rem = w_fits ? w_diff : w_shift;
                w_next.qd  = {r_stage[gi-1].qd[WIDTH-2:0], w_fits};
            end

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    r_stage[gi] <= '0;
                end else if (ready_in) begin
                    r_stage[gi] <= w_next;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------- output stage
    logic [WIDTH-1:0] w_quotient;
    logic [WIDTH-1:0] w_remainder;

    always_comb begin
        w_quotient  = r_stage[WIDTH].qd;
        w_remainder = r_stage[WIDTH].rem[WIDTH-1:0];
        if (r_stage[WIDTH].err) begin
            w_quotient  = {WIDTH{1'b1}};
            w_remainder = r_stage[WIDTH].raw;
        end else if (r_stage[WIDTH].ovf) begin
            w_quotient  = r_stage[WIDTH].raw;
            w_remainder = '0;
        end else begin
            if (r_stage[WIDTH].qneg) begin
                w_quotient = -r_stage[WIDTH].qd;
            end
            if (r_stage[WIDTH].rneg) begin
                w_remainder = -r_stage[WIDTH].rem[WIDTH-1:0];
            end
        end
    end

    // busy reflects the valid bits as they will be after this edge.
    logic [WIDTH:0] w_stage_valid;
    logic           w_busy_next;

    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : gen_valid_tap
            assign w_stage_valid[gi] = r_stage[gi].valid;
        end
    endgenerate

    assign w_busy_next = data_valid_in | r_cap_valid | (|w_stage_valid);

    logic                 r_valid_out;
    logic [WIDTH-1:0]     r_quotient;
    logic [WIDTH-1:0]     r_remainder;
    logic [TAG_WIDTH-1:0] r_tag_out;
    logic                 r_error;
    logic                 r_overflow;
    logic                 r_busy;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid_out <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_tag_out   <= '0;
            r_error     <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
        end else if (ready_in) begin
            r_valid_out <= r_stage[WIDTH].valid;
            r_busy      <= w_busy_next;
            // Result fields only move with a real result so they hold
            // their last values between results.
            if (r_stage[WIDTH].valid) begin
                r_quotient  <= w_quotient;
                r_remainder <= w_remainder;
                r_tag_out   <= r_stage[WIDTH].tag;
                r_error     <= r_stage[WIDTH].err;
                r_overflow  <= r_stage[WIDTH].ovf;
            end
        end
    end

    assign ready_out      = ready_in;
    assign data_valid_out = r_valid_out;
    assign quotient_out   = r_quotient;
    assign remainder_out  = r_remainder;
    assign tag_out        = r_tag_out;
    assign error_out      = r_error;
    assign overflow_out   = r_overflow;
    assign busy_out       = r_busy;

endmodule

// File: tb/tb_pipelined_divider.sv
// -----------------------------------------------------------------------------
// tb_pipelined_divider
//
// Four divider instances share one stimulus bus: 9-bit unsigned, 9-bit signed,
// 4-bit unsigned, 4-bit signed. One of them is selected for observation at a
// time. Fixed vectors come from a table, streaming traffic is checked against
// an arithmetic reference model through an expected-result queue.
// -----------------------------------------------------------------------------
module tb_pipelined_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       vin;
    logic       rdy;
    logic [8:0] a9;
    logic [8:0] b9;
    logic [3:0] tg;

    logic       ro0, dv0, e0, o0, bz0;
    logic [8:0] q0, r0;
    logic [3:0] t0;
    logic       ro1, dv1, e1, o1, bz1;
    logic [8:0] q1, r1;
    logic [3:0] t1;
    logic       ro2, dv2, e2, o2, bz2;
    logic [3:0] q2, r2;
    logic [3:0] t2;
    logic       ro3, dv3, e3, o3, bz3;
    logic [3:0] q3, r3;
    logic [3:0] t3;

    pipelined_divider #(.WIDTH(9), .SIGNED(0), .TAG_WIDTH(4)) u_w9u (
        .clk_in(clk), .rst_in(rst), .data_valid_in(vin), .dividend_in(a9),
        .divisor_in(b9), .tag_in(tg), .ready_in(rdy), .ready_out(ro0),
        .data_valid_out(dv0), .quotient_out(q0), .remainder_out(r0), .tag_out(t0),
        .error_out(e0), .overflow_out(o0), .busy_out(bz0));

    pipelined_divider #(.WIDTH(9), .SIGNED(1), .TAG_WIDTH(4)) u_w9s (
        .clk_in(clk), .rst_in(rst), .data_valid_in(vin), .dividend_in(a9),
        .divisor_in(b9), .tag_in(tg), .ready_in(rdy), .ready_out(ro1),
        .data_valid_out(dv1), .quotient_out(q1), .remainder_out(r1), .tag_out(t1),
        .error_out(e1), .overflow_out(o1), .busy_out(bz1));

    pipelined_divider #(.WIDTH(4), .SIGNED(0), .TAG_WIDTH(4)) u_w4u (
        .clk_in(clk), .rst_in(rst), .data_valid_in(vin), .dividend_in(a9[3:0]),
        .divisor_in(b9[3:0]), .tag_in(tg), .ready_in(rdy), .ready_out(ro2),
        .data_valid_out(dv2), .quotient_out(q2), .remainder_out(r2), .tag_out(t2),
        .error_out(e2), .overflow_out(o2), .busy_out(bz2));

    pipelined_divider #(.WIDTH(4), .SIGNED(1), .TAG_WIDTH(4)) u_w4s (
        .clk_in(clk), .rst_in(rst), .data_valid_in(vin), .dividend_in(a9[3:0]),
        .divisor_in(b9[3:0]), .tag_in(tg), .ready_in(rdy), .ready_out(ro3),
        .data_valid_out(dv3), .quotient_out(q3), .remainder_out(r3), .tag_out(t3),
        .error_out(e3), .overflow_out(o3), .busy_out(bz3));

    typedef struct packed {
        logic       dv;
        logic [8:0] q;
        logic [8:0] r;
        logic [3:0] t;
        logic       e;
        logic       o;
        logic       bz;
    } obs_t;

    typedef struct packed {
        logic [8:0] q;
        logic [8:0] r;
        logic [3:0] t;
        logic       e;
        logic       o;
    } res_t;

    typedef struct {
        int         inst;
        logic [8:0] a;
        logic [8:0] b;
        logic [3:0] tag;
        logic [8:0] eq;
        logic [8:0] er;
        logic       ee;
        logic       eo;
    } vec_t;

    int   mon_sel;
    bit   mon_en;
    obs_t cur;

    always_comb begin
        cur = '0;
        case (mon_sel)
            0: cur = '{dv: dv0, q: q0, r: r0, t: t0, e: e0, o: o0, bz: bz0};
            1: cur = '{dv: dv1, q: q1, r: r1, t: t1, e: e1, o: o1, bz: bz1};
            2: cur = '{dv: dv2, q: {5'd0, q2}, r: {5'd0, r2}, t: t2, e: e2, o: o2, bz: bz2};
            default: cur = '{dv: dv3, q: {5'd0, q3}, r: {5'd0, r3}, t: t3, e: e3, o: o3, bz: bz3};
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_unexp  = 0;
    bit seen_ignored = 1'b0;
    res_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division on the operand values.
    function automatic res_t model(input int w, input bit sgn, input logic [8:0] a,
                                   input logic [8:0] b, input logic [3:0] t);
        res_t res;
        int mask, ua, ub, sa, sb, half;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        ua   = int'(a) & mask;
        ub   = int'(b) & mask;
        sa   = (sgn && ua >= half) ? ua - (1 << w) : ua;
        sb   = (sgn && ub >= half) ? ub - (1 << w) : ub;
        res  = '0;
        res.t = t;
        if (ub == 0) begin
            res.e = 1'b1;
            res.q = 9'(mask);
            res.r = 9'(ua);
        end else if (sgn && sa == -half && sb == -1) begin
            res.o = 1'b1;
            res.q = 9'(ua);
            res.r = 9'd0;
        end else if (sgn) begin
            res.q = 9'((sa / sb) & mask);
            res.r = 9'((sa % sb) & mask);
        end else begin
            res.q = 9'(ua / ub);
            res.r = 9'(ua % ub);
        end
        return res;
    endfunction

    // Stream monitor: consumes results of the selected instance in order and
    // checks that nothing moves across a stalled edge.
    obs_t prev;
    logic prev_rdy;
    bit   have_prev = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (have_prev && !prev_rdy) begin
                chk("stall_hold", 32'(cur), 32'(prev));
            end
            if (cur.dv && rdy) begin
                if (cur.t == 4'hF) seen_ignored = 1'b1;
                if (exp_q.size() == 0) begin
                    n_unexp++;
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    $display("stream inst%0d: q=%0h r=%0h tag=%0h err=%0b ovf=%0b", mon_sel,
                             cur.q, cur.r, cur.t, cur.e, cur.o);
                    chk("stream.q", 32'(cur.q), 32'(e.q));
                    chk("stream.r", 32'(cur.r), 32'(e.r));
                    chk("stream.tag", 32'(cur.t), 32'(e.t));
                    chk("stream.err", 32'(cur.e), 32'(e.e));
                    chk("stream.ovf", 32'(cur.o), 32'(e.o));
                end
            end
            prev      = cur;
            prev_rdy  = rdy;
            have_prev = 1'b1;
        end else begin
            have_prev = 1'b0;
        end
    end

    // Issue one operation and time its result on the selected instance.
    task automatic run_one(input vec_t v, input string name);
        int lat;
        bit got;
        mon_sel = v.inst;
        @(posedge clk); #1;
        rdy = 1'b1; vin = 1'b1; a9 = v.a; b9 = v.b; tg = v.tag;
        @(posedge clk); #1;
        vin = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (cur.dv) got = 1'b1;
        end
        $display("%s: inst%0d a=%0h b=%0h -> q=%0h r=%0h tag=%0h err=%0b ovf=%0b lat=%0d",
                 name, v.inst, v.a, v.b, cur.q, cur.r, cur.t, cur.e, cur.o, lat);
        chk({name, ".latency"}, 32'(lat), 32'd11);
        if (got) begin
            chk({name, ".q"}, 32'(cur.q), 32'(v.eq));
            chk({name, ".r"}, 32'(cur.r), 32'(v.er));
            chk({name, ".tag"}, 32'(cur.t), 32'(v.tag));
            chk({name, ".err"}, 32'(cur.e), 32'(v.ee));
            chk({name, ".ovf"}, 32'(cur.o), 32'(v.eo));
        end
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rdy = 1'b1; vin = 1'b0;
        end
    endtask

    vec_t tbl[11];

    initial begin
        int issued, cyc, seen;
        vec_t v;

        tbl[0]  = '{0, 9'd64,  9'd40,  4'd1,  9'd1,   9'd24,  1'b0, 1'b0};
        tbl[1]  = '{0, 9'd40,  9'd4,   4'd2,  9'd10,  9'd0,   1'b0, 1'b0};
        tbl[2]  = '{1, 9'h1F9, 9'd2,   4'd3,  9'h1FD, 9'h1FF, 1'b0, 1'b0};
        tbl[3]  = '{1, 9'd7,   9'h1FE, 4'd4,  9'h1FD, 9'd1,   1'b0, 1'b0};
        tbl[4]  = '{1, 9'h1F8, 9'h1FE, 4'd5,  9'd4,   9'd0,   1'b0, 1'b0};
        tbl[5]  = '{0, 9'd100, 9'd0,   4'd6,  9'h1FF, 9'd100, 1'b1, 1'b0};
        tbl[6]  = '{1, 9'h100, 9'h1FF, 4'd7,  9'h100, 9'd0,   1'b0, 1'b1};
        tbl[7]  = '{1, 9'h1F9, 9'd0,   4'd8,  9'h1FF, 9'h1F9, 1'b1, 1'b0};
        tbl[8]  = '{0, 9'd511, 9'd1,   4'd9,  9'd511, 9'd0,   1'b0, 1'b0};
        tbl[9]  = '{1, 9'h100, 9'd1,   4'd10, 9'h100, 9'd0,   1'b0, 1'b0};
        tbl[10] = '{0, 9'd5,   9'd7,   4'd11, 9'd0,   9'd5,   1'b0, 1'b0};

        mon_en = 1'b0; mon_sel = 0;
        rst = 1'b1; vin = 1'b0; rdy = 1'b1; a9 = '0; b9 = '0; tg = '0;

        // ---------------- reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            mon_sel = s;
            #0;
            $display("reset inst%0d: dv=%0b busy=%0b q=%0h r=%0h tag=%0h", s, cur.dv, cur.bz,
                     cur.q, cur.r, cur.t);
            chk("reset.state", 32'(cur), 32'd0);
        end
        chk("ready_out.high", 32'(ro0), 32'(rdy));
        rdy = 1'b0;
        #1 chk("ready_out.low", 32'(ro0), 32'(rdy));
        chk("ready_out.low_s", 32'(ro3), 32'(rdy));
        rdy = 1'b1;

        // ---------------- table of single operations
        for (int i = 0; i < 11; i++) begin
            run_one(tbl[i], $sformatf("vec%0d", i));
        end
        drain(15);

        // ---------------- back-to-back with exact timing
        mon_sel = 0;
        @(posedge clk); #1;
        vin = 1'b1; a9 = 9'd64; b9 = 9'd40; tg = 4'd1;
        @(posedge clk); #1;
        a9 = 9'd40; b9 = 9'd4; tg = 4'd2;
        @(posedge clk); #1;
        vin = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        $display("b2b cycle10: dv=%0b busy=%0b", cur.dv, cur.bz);
        chk("b2b.early_valid", 32'(cur.dv), 32'd0);
        chk("b2b.busy_mid", 32'(cur.bz), 32'd1);
        @(posedge clk); @(negedge clk);
        $display("b2b cycle11: dv=%0b q=%0h r=%0h tag=%0h", cur.dv, cur.q, cur.r, cur.t);
        chk("b2b.first.dv", 32'(cur.dv), 32'd1);
        chk("b2b.first.q", 32'(cur.q), 32'd1);
        chk("b2b.first.r", 32'(cur.r), 32'd24);
        chk("b2b.first.tag", 32'(cur.t), 32'd1);
        @(posedge clk); @(negedge clk);
        $display("b2b cycle12: dv=%0b q=%0h r=%0h tag=%0h busy=%0b", cur.dv, cur.q, cur.r,
                 cur.t, cur.bz);
        chk("b2b.second.dv", 32'(cur.dv), 32'd1);
        chk("b2b.second.q", 32'(cur.q), 32'd10);
        chk("b2b.second.r", 32'(cur.r), 32'd0);
        chk("b2b.second.tag", 32'(cur.t), 32'd2);
        chk("b2b.busy_last", 32'(cur.bz), 32'd1);
        @(posedge clk); @(negedge clk);
        $display("b2b cycle13: dv=%0b busy=%0b", cur.dv, cur.bz);
        chk("b2b.valid_drop", 32'(cur.dv), 32'd0);
        chk("b2b.busy_drop", 32'(cur.bz), 32'd0);
        drain(3);

        // ---------------- random stream with backpressure
        mon_sel = 0;
        exp_q.delete();
        seen_ignored = 1'b0;
        mon_en = 1'b1;
        issued = 0;
        cyc = 0;
        while (issued < 20 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            rdy = ($urandom_range(0, 99) < 60);
            if (rdy) begin
                vin = ($urandom_range(0, 3) != 0);
                a9  = 9'($urandom_range(0, 511));
                case ($urandom_range(0, 3))
                    0: b9 = 9'd0;
                    1: b9 = 9'($urandom_range(1, 15));
                    default: b9 = 9'($urandom_range(1, 511));
                endcase
                tg = 4'(issued % 15);
                if (vin) begin
                    exp_q.push_back(model(9, 1'b0, a9, b9, tg));
                    issued++;
                end
            end else begin
                // Offered while stalled: must never be taken.
                vin = 1'b1; a9 = 9'd5; b9 = 9'd1; tg = 4'hF;
            end
        end
        while (exp_q.size() != 0 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            vin = 1'b0;
            rdy = ($urandom_range(0, 99) < 60);
        end
        mon_en = 1'b0;
        $display("stream done: issued=%0d pending=%0d unexpected=%0d", issued, exp_q.size(),
                 n_unexp);
        chk("stream.issued", 32'(issued), 32'd20);
        chk("stream.pending", 32'(exp_q.size()), 32'd0);
        chk("stream.unexpected", 32'(n_unexp), 32'd0);
        chk("stream.ignored_op", 32'(seen_ignored), 32'd0);
        drain(20);

        // ---------------- reset while operations are in flight
        mon_sel = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vin = 1'b1; a9 = 9'(100 + i); b9 = 9'd3; tg = 4'(12 + i);
        end
        @(posedge clk); #1;
        vin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        $display("mid-reset: dv=%0b busy=%0b", cur.dv, cur.bz);
        chk("rst.dv", 32'(cur.dv), 32'd0);
        chk("rst.busy", 32'(cur.bz), 32'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (cur.dv) seen++;
        end
        chk("rst.ghost_results", 32'(seen), 32'd0);
        v = '{0, 9'd9, 9'd3, 4'd5, 9'd3, 9'd0, 1'b0, 1'b0};
        run_one(v, "after_rst");
        drain(15);

        // ---------------- exhaustive 4-bit, unsigned then signed
        for (int s = 2; s < 4; s++) begin
            mon_sel = s;
            exp_q.delete();
            n_unexp = 0;
            mon_en = 1'b1;
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    @(posedge clk); #1;
                    rdy = 1'b1; vin = 1'b1;
                    a9 = 9'(a); b9 = 9'(b); tg = 4'(a ^ b);
                    exp_q.push_back(model(4, (s == 3), a9, b9, tg));
                end
            end
            @(posedge clk); #1;
            vin = 1'b0;
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 30) begin
                @(posedge clk); #1;
                cyc++;
            end
            mon_en = 1'b0;
            $display("exhaustive inst%0d: pending=%0d unexpected=%0d", s, exp_q.size(), n_unexp);
            chk("exh.pending", 32'(exp_q.size()), 32'd0);
            chk("exh.unexpected", 32'(n_unexp), 32'd0);
            drain(10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
